// File: rtl/fifo_word_packer.sv
// Packs PACK consecutive bytes popped from an async FIFO read port into one wide valid/ready word.
// Optional idle-timeout flush of partial words is enabled by defining FIFO_WORD_PACKER_TIMEOUT_EN.
module fifo_word_packer #(
  parameter int DATA_W  = 8,
  parameter int PACK    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     rclk,
  input  logic                     rrst,
  output logic                     rinc,
  input  logic [DATA_W-1:0]        rdata,
  input  logic                     rempty,
  input  logic                     rempty_almost,
  output logic [DATA_W*PACK-1:0]   out_data,
  output logic [PACK-1:0]          out_keep,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     low_water
);

  localparam int CNT_W  = $clog2(PACK + 1);
  localparam int LANE_W = $clog2(PACK);
  localparam logic [CNT_W-1:0] PACK_CNT = CNT_W'(PACK);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              state_reg;
  logic [CNT_W-1:0]    issued_reg;
  logic [CNT_W-1:0]    filled_reg;
  logic                pending_reg;
  logic [LANE_W-1:0]   pend_lane_reg;
  logic [DATA_W-1:0]   lane_reg [PACK];
  logic                out_valid_reg;
  logic [PACK-1:0]     out_keep_reg;
  logic                out_last_reg;
  logic                low_water_reg;

  logic                fill_done;
  logic                flush_due;
  logic                hold_next;

`ifdef FIFO_WORD_PACKER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] TIMEOUT_CNT = IDLE_W'(TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_ONE    = IDLE_W'(1);

  logic [IDLE_W-1:0]   idle_reg;
  logic                idle_run;
  logic [PACK-1:0]     keep_partial;

  assign flush_due = (state_reg == FILL) && (idle_reg == TIMEOUT_CNT);
  assign idle_run  = (state_reg == FILL) && (filled_reg != '0) && (filled_reg < PACK_CNT)
                     && !rinc && !pending_reg;
`else
  assign flush_due = 1'b0;
`endif

  // Pops are suppressed on the flush edge so no byte can be in flight when the word closes.
  assign rinc = !rrst && (state_reg == FILL) && !rempty && (issued_reg < PACK_CNT) && !flush_due;

  assign fill_done = (state_reg == FILL) && pending_reg && ((filled_reg + CNT_ONE) == PACK_CNT);
  assign hold_next = ((state_reg == HOLD) && !out_ready) || fill_done || flush_due;

  for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
    assign out_data[gi*DATA_W +: DATA_W] = lane_reg[gi];
`ifdef FIFO_WORD_PACKER_TIMEOUT_EN
    assign keep_partial[gi] = (CNT_W'(gi) < filled_reg);
`endif
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_reg     <= FILL;
      issued_reg    <= '0;
      filled_reg    <= '0;
      pending_reg   <= 1'b0;
      pend_lane_reg <= '0;
      out_valid_reg <= 1'b0;
      out_keep_reg  <= '0;
      out_last_reg  <= 1'b0;
      low_water_reg <= 1'b0;
      for (int i = 0; i < PACK; i++) begin
        lane_reg[i] <= '0;
      end
`ifdef FIFO_WORD_PACKER_TIMEOUT_EN
      idle_reg      <= '0;
`endif
    end else begin
      case (state_reg)
        FILL: begin
          if (rinc) begin
            issued_reg <= issued_reg + CNT_ONE;
          end
          // The FIFO presents the popped byte after the pop edge; remember which lane it owns.
          pending_reg   <= rinc;
          pend_lane_reg <= LANE_W'(issued_reg);
          if (pending_reg) begin
            lane_reg[pend_lane_reg] <= rdata;
            filled_reg              <= filled_reg + CNT_ONE;
          end
          if (fill_done) begin
            state_reg     <= HOLD;
            out_valid_reg <= 1'b1;
            out_keep_reg  <= '1;
            out_last_reg  <= 1'b0;
          end
`ifdef FIFO_WORD_PACKER_TIMEOUT_EN
          if (flush_due) begin
            state_reg     <= HOLD;
            out_valid_reg <= 1'b1;
            out_keep_reg  <= keep_partial;
            out_last_reg  <= 1'b1;
            idle_reg      <= '0;
          end else if (rinc || fill_done) begin
            idle_reg <= '0;
          end else if (idle_run) begin
            idle_reg <= idle_reg + IDLE_ONE;
          end
`endif
        end
        HOLD: begin
          if (out_ready) begin
            state_reg     <= FILL;
            issued_reg    <= '0;
            filled_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_keep_reg  <= '0;
            out_last_reg  <= 1'b0;
            for (int i = 0; i < PACK; i++) begin
              lane_reg[i] <= '0;
            end
          end
        end
        default: begin
          state_reg <= FILL;
        end
      endcase
      low_water_reg <= rempty_almost && !hold_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_keep  = out_keep_reg;
  assign out_last  = out_last_reg;
  assign low_water = low_water_reg;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Self-checking bench for fifo_word_packer: behavioural FIFO source, scenario tasks, word-level model.
module tb_fifo_word_packer;

  localparam int DATA_W  = 8;
  localparam int PACK    = 4;
  localparam int TIMEOUT = 16;

  logic                   rclk = 1'b0;
  logic                   rrst;
  logic                   rinc;
  logic [DATA_W-1:0]      rdata;
  logic                   rempty;
  logic                   rempty_almost;
  logic [DATA_W*PACK-1:0] out_data;
  logic [PACK-1:0]        out_keep;
  logic                   out_last;
  logic                   out_valid;
  logic                   out_ready;
  logic                   low_water;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [0:1023];
  int wr_ptr   = 0;
  int rd_ptr   = 0;
  int pop_cnt  = 0;
  int bad_rinc = 0;

  fifo_word_packer #(
    .DATA_W (DATA_W),
    .PACK   (PACK),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .rclk         (rclk),
    .rrst         (rrst),
    .rinc         (rinc),
    .rdata        (rdata),
    .rempty       (rempty),
    .rempty_almost(rempty_almost),
    .out_data     (out_data),
    .out_keep     (out_keep),
    .out_last     (out_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .low_water    (low_water)
  );

  always #5 rclk = ~rclk;

  // Behavioural FIFO read side: registered data, combinational empty.
  assign rempty = (wr_ptr == rd_ptr);

  always @(posedge rclk) begin
    if (rinc && !rempty) begin
      rdata  <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
    if (rinc) pop_cnt <= pop_cnt + 1;
    if (rinc && (rempty || out_valid)) bad_rinc <= bad_rinc + 1;
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_word(input int budget, output bit got, output int waited);
    got = 1'b0;
    waited = 0;
    while (!got && waited < budget) begin
      @(negedge rclk);
      waited++;
      if (out_valid) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    rrst = 1'b1;
    out_ready = 1'b0;
    rempty_almost = 1'b1;
    repeat (2) @(negedge rclk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_keep !== 4'h0) begin failures++; $display("FAIL reset_keep: got %b want 0000", out_keep); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_last: got %b want 0", out_last); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_data: got %h want 00000000", out_data); end
    checks++; if (low_water !== 1'b0) begin failures++; $display("FAIL reset_low_water: got %b want 0", low_water); end
    checks++; if (rinc !== 1'b0) begin failures++; $display("FAIL reset_rinc: got %b want 0", rinc); end
    rempty_almost = 1'b0;
    rrst = 1'b0;
    @(negedge rclk);
    $display("reset done");
  endtask

  task automatic test_single_word();
    bit got;
    int w;
    int p0;
    p0 = pop_cnt;
    out_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wait_word(40, got, w);
    checks++; if (!got) begin failures++; $display("FAIL single_timeout: got no word want word within 40 cycles"); end
    $display("single word data=%h keep=%b last=%b cycles=%0d", out_data, out_keep, out_last, w);
    checks++; if (out_data !== 32'h44332211) begin failures++; $display("FAIL single_data: got %h want 44332211", out_data); end
    checks++; if (out_keep !== 4'hF || out_last !== 1'b0) begin failures++; $display("FAIL single_keep_last: got %b/%b want 1111/0", out_keep, out_last); end
    checks++; if (w !== PACK + 1) begin failures++; $display("FAIL single_latency: got %0d want %0d", w, PACK + 1); end
    @(negedge rclk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_one_cycle: got valid %b want 0", out_valid); end
    checks++; if (pop_cnt - p0 !== 4) begin failures++; $display("FAIL single_pops: got %0d want 4", pop_cnt - p0); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_pressure();
    bit got;
    int w;
    int p1;
    logic [31:0] held;
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    wait_word(40, got, w);
    checks++; if (!got || out_data !== 32'h04030201) begin failures++; $display("FAIL bp_first: got valid %b data %h want 1 04030201", got, out_data); end
    $display("bp word data=%h keep=%b", out_data, out_keep);
    held = out_data;
    p1 = pop_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge rclk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== held) begin
        failures++; $display("FAIL bp_stable: cycle %0d got %b/%h want 1/%h", i, out_valid, out_data, held);
      end
    end
    checks++; if (pop_cnt !== p1) begin failures++; $display("FAIL bp_no_pop: got %0d pops want 0", pop_cnt - p1); end
    out_ready = 1'b1;
    wait_word(40, got, w);
    $display("bp word data=%h keep=%b", out_data, out_keep);
    checks++; if (!got || out_data !== 32'h08070605 || out_keep !== 4'hF) begin failures++; $display("FAIL bp_second: got %b %h %b want 1 08070605 1111", got, out_data, out_keep); end
    @(negedge rclk);
    out_ready = 1'b0;
  endtask

  task automatic test_sparse();
    logic [7:0] sb [4];
    int b0;
    int p0;
    sb = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    b0 = bad_rinc;
    p0 = pop_cnt;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(sb[i]);
      repeat (5) @(negedge rclk);
    end
    $display("sparse word data=%h valid=%b", out_data, out_valid);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hDDCCBBAA) begin failures++; $display("FAIL sparse_word: got %b/%h want 1/ddccbbaa", out_valid, out_data); end
    checks++; if (bad_rinc !== b0) begin failures++; $display("FAIL sparse_rinc_gate: got %0d illegal pops want 0", bad_rinc - b0); end
    checks++; if (pop_cnt - p0 !== 4) begin failures++; $display("FAIL sparse_pops: got %0d want 4", pop_cnt - p0); end
    out_ready = 1'b1;
    @(negedge rclk);
    out_ready = 1'b0;
  endtask

  task automatic test_random_stream();
    logic [7:0]  exp_q [$];
    logic [31:0] exp_w;
    logic [31:0] prev_data;
    logic [7:0]  b;
    bit prev_held;
    int pushed;
    int words;
    int guard;
    int b0;
    pushed = 0; words = 0; guard = 0; prev_held = 1'b0; prev_data = '0;
    b0 = bad_rinc;
    out_ready = 1'b0;
    while (words < 12 && guard < 4000) begin
      @(negedge rclk);
      guard++;
      if (prev_held) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          failures++; $display("FAIL rand_hold: got %b/%h want 1/%h", out_valid, out_data, prev_data);
        end
      end
      if (out_valid && $urandom_range(0, 2) != 0) begin
        out_ready = 1'b1;
        exp_w = '0;
        for (int k = 0; k < PACK; k++) begin
          if (exp_q.size() > 0) exp_w[k*8 +: 8] = exp_q.pop_front();
        end
        checks++;
        if (out_data !== exp_w || out_keep !== 4'hF || out_last !== 1'b0) begin
          failures++; $display("FAIL rand_word: word %0d got %h/%b/%b want %h/1111/0", words, out_data, out_keep, out_last, exp_w);
        end
        $display("rand word %0d data=%h", words, out_data);
        words++;
        prev_held = 1'b0;
      end else begin
        out_ready = 1'b0;
        prev_held = out_valid;
        prev_data = out_data;
      end
      if (pushed < 12 * PACK && $urandom_range(0, 3) != 0) begin
        b = 8'($urandom);
        push(b);
        exp_q.push_back(b);
        pushed++;
      end
    end
    checks++; if (words !== 12) begin failures++; $display("FAIL rand_count: got %0d words want 12", words); end
    checks++; if (bad_rinc !== b0) begin failures++; $display("FAIL rand_rinc_gate: got %0d illegal pops want 0", bad_rinc - b0); end
    @(negedge rclk);
    out_ready = 1'b0;
  endtask

  task automatic test_timeout();
    bit got;
    int w;
`ifdef FIFO_WORD_PACKER_TIMEOUT_EN
    out_ready = 1'b0;
    push(8'hA5); push(8'h5A);
    wait_word(100, got, w);
    $display("timeout word data=%h keep=%b last=%b cycles=%0d", out_data, out_keep, out_last, w);
    checks++; if (!got) begin failures++; $display("FAIL to_flush: got no word want flush within 100 cycles"); end
    checks++; if (out_data !== 32'h00005AA5 || out_keep !== 4'b0011 || out_last !== 1'b1) begin failures++; $display("FAIL to_word: got %h/%b/%b want 00005aa5/0011/1", out_data, out_keep, out_last); end
    checks++; if (w < 2 + TIMEOUT || w > 5 + TIMEOUT) begin failures++; $display("FAIL to_delay: got %0d cycles want %0d..%0d", w, 2 + TIMEOUT, 5 + TIMEOUT); end
    out_ready = 1'b1;
    @(negedge rclk);
    out_ready = 1'b0;
    push(8'h21); push(8'h22); push(8'h23); push(8'h24);
    wait_word(40, got, w);
    $display("timeout follow word data=%h", out_data);
    checks++; if (!got || out_data !== 32'h24232221 || out_keep !== 4'hF || out_last !== 1'b0) begin failures++; $display("FAIL to_after: got %b %h %b %b want 1 24232221 1111 0", got, out_data, out_keep, out_last); end
    out_ready = 1'b1;
    @(negedge rclk);
    out_ready = 1'b0;
`else
    int seen;
    seen = 0;
    out_ready = 1'b1;
    push(8'hA5); push(8'h5A);
    repeat (100) begin
      @(negedge rclk);
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL no_timeout: got %0d valid cycles want 0", seen); end
    push(8'h01); push(8'h02);
    wait_word(40, got, w);
    $display("partial completion word data=%h", out_data);
    checks++; if (!got || out_data !== 32'h02015AA5 || out_keep !== 4'hF || out_last !== 1'b0) begin failures++; $display("FAIL partial_resume: got %b %h %b %b want 1 02015aa5 1111 0", got, out_data, out_keep, out_last); end
    @(negedge rclk);
    out_ready = 1'b0;
`endif
  endtask

  task automatic test_reset_mid_word();
    bit got;
    int w;
    out_ready = 1'b1;
    push(8'h31); push(8'h32); push(8'h33);
    repeat (3) @(negedge rclk);
    rrst = 1'b1;
    @(negedge rclk);
    checks++; if (out_valid !== 1'b0 || out_keep !== 4'h0 || out_last !== 1'b0) begin failures++; $display("FAIL mid_reset_ctrl: got %b/%b/%b want 0/0000/0", out_valid, out_keep, out_last); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL mid_reset_data: got %h want 00000000", out_data); end
    checks++; if (low_water !== 1'b0 || rinc !== 1'b0) begin failures++; $display("FAIL mid_reset_misc: got lw %b rinc %b want 0 0", low_water, rinc); end
    rrst = 1'b0;
    push(8'h10); push(8'h11); push(8'h12); push(8'h13);
    wait_word(40, got, w);
    $display("post-reset word data=%h", out_data);
    checks++; if (!got || out_data !== 32'h13121110 || out_keep !== 4'hF) begin failures++; $display("FAIL mid_reset_word: got %b %h %b want 1 13121110 1111", got, out_data, out_keep); end
    @(negedge rclk);
    out_ready = 1'b0;
  endtask

  task automatic test_status();
    bit got;
    int w;
    logic ra;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ra = 1'($urandom_range(0, 1));
      rempty_almost = ra;
      @(negedge rclk);
      checks++; if (low_water !== ra) begin failures++; $display("FAIL status_fill: step %0d got %b want %b", i, low_water, ra); end
    end
    push(8'h41); push(8'h42); push(8'h43); push(8'h44);
    wait_word(40, got, w);
    rempty_almost = 1'b1;
    @(negedge rclk);
    checks++; if (out_valid !== 1'b1 || low_water !== 1'b0) begin failures++; $display("FAIL status_hold: got valid %b lw %b want 1 0", out_valid, low_water); end
    out_ready = 1'b1;
    @(negedge rclk);
    checks++; if (out_valid !== 1'b0 || low_water !== 1'b1) begin failures++; $display("FAIL status_refill: got valid %b lw %b want 0 1", out_valid, low_water); end
    $display("status word data=%h", dut.out_data);
    out_ready = 1'b0;
    rempty_almost = 1'b0;
  endtask

  initial begin
    rrst = 1'b1;
    out_ready = 1'b0;
    rempty_almost = 1'b0;
    test_reset();
    test_single_word();
    test_back_pressure();
    test_sparse();
    test_random_stream();
    test_timeout();
    test_reset_mid_word();
    test_status();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fifo_word_packer.md
# fifo_word_packer

Read-clock-domain drain stage that sits directly downstream of the team's asynchronous FIFO. It pops bytes through the FIFO's `rinc`/`rdata`/`rempty` read port and packs PACK consecutive bytes into one wide word, first byte in lane 0. It presents each word on a valid/ready stream to the consumer. An optional timeout flush emits partially filled words so trailing bytes do not stall.

## Interface
- `DATA_W`, 8: FIFO data width, equal to the FIFO's data width.
- `PACK`, 4: bytes per output word, ≥2.
- `TIMEOUT`, 16: idle rclk cycles before a partial word is flushed, ≥2. Used only with the macro.
- `rclk`  in  1: read-domain clock, shared with the FIFO read side.
- `rrst`  in  1: reset, synchronous, active-high.
- `rinc`  out  1: pop request to the FIFO.
- `rdata`  in  DATA_W: FIFO read data, registered inside the FIFO.
- `rempty`  in  1: FIFO empty flag.
- `rempty_almost`  in  1: FIFO almost-empty flag, used for the status output only.
- `out_data`  out  DATA_W*PACK: packed word. Byte k is in bits [k*DATA_W +: DATA_W].
- `out_keep`  out  PACK: lane-valid mask.
- `out_last`  out  1: marks a flushed partial word.
- `out_valid`  out  1: word available.
- `out_ready`  in  1: consumer accepts the word.
- `low_water`  out  1: registered copy of `rempty_almost` while in FILL, else 0.

## Operation
- **States:** FILL (collecting bytes) and HOLD (word presented on the output).
- **Pop rule:** `rinc` = FILL && !rempty && (issued < PACK). It is combinational.
  - A pop is accepted on an rclk edge where rinc=1 and rempty=0. `issued` increments on that edge.
  - The FIFO drives the popped byte on `rdata` after that edge. The packer captures it one edge later into lane `issued_at_pop`. It tracks this with a 1-bit `pending` flag plus the lane index.
- **`filled` counter:** increments on each capture.
- **FILL → HOLD:** when `filled` reaches PACK, i.e. on the capture of the last byte.
  - out_keep = all ones, out_last = 0.
- **HOLD:**
  - out_valid = 1. out_data, out_keep and out_last are stable, and `rinc` = 0.
  - When out_valid && out_ready is sampled on an edge: return to FILL, clear `issued`, `filled` and all lanes to 0, and drop out_valid.
- **Lane contents:** lanes not yet filled read 0.
- **Arithmetic:** `issued` and `filled` are $clog2(PACK+1) bits wide and never exceed PACK.
- **Stale data:** `rdata` is never sampled except on the capture edge following an accepted pop.

## Timing
- **Reset** (rrst sampled high on an edge): state = FILL, issued = filled = 0, pending = 0, all lanes = 0, out_valid = 0, out_keep = 0, out_last = 0, low_water = 0, idle counter = 0.
  - `rinc` is 0 while rrst = 1.
  - A byte popped the cycle before reset is discarded.
- **Latency:** last accepted pop on edge E, capture on E+1, out_valid = 1 after E+1.
- **Throughput:** with the FIFO never empty, one pop per cycle for PACK cycles, then ≥1 cycle in HOLD. That gives a minimum of PACK+2 cycles per word.
- **Back-pressure:** out_ready may be held low indefinitely. No pops occur and no output changes while it is low.
- **Empty:** with rempty=1, no pop is issued and FILL holds its partial state.
- **Underflow:** if rempty rises in the same cycle as a would-be pop, rinc is still gated. The FIFO's own empty-lookahead keeps this safe.
- **Consumer side:** out_ready while out_valid=0 is ignored.

## Configuration
- **Macro:** `FIFO_WORD_PACKER_TIMEOUT_EN`.
- **Defined:**
  - An idle counter runs in FILL when 0 < filled < PACK, no pop is accepted this cycle, and pending = 0. Any accepted pop clears it.
  - When it reaches TIMEOUT, the next edge enters HOLD with out_keep = (1<<filled)-1 and out_last = 1. The `issued` value is frozen.
  - The counter is cleared on entering HOLD.
- **Undefined:**
  - No idle counter. Partial words wait indefinitely.
  - out_keep is always all ones in HOLD, out_last is tied 0, and TIMEOUT is unused.

## Test plan
- **Single word:** reset, then FIFO preloaded with 0x11,0x22,0x33,0x44, out_ready=1. Expect 4 consecutive rinc pulses, then out_data=0x44332211, out_keep=4'b1111, out_last=0, out_valid high for exactly one cycle.
- **Back-pressure:** 8 bytes 0x01..0x08, out_ready=0 for 20 cycles then 1. Expect the first word 0x04030201 held stable for all 20 cycles and no rinc during HOLD. Then 0x08070605.
- **Sparse source:** bytes arrive in the FIFO one every 5 cycles. Expect rinc only when rempty=0 and a correct word 0xDDCCBBAA for input AA,BB,CC,DD.
- **Timeout** (macro on, TIMEOUT=16): 2 bytes 0xA5,0x5A then FIFO empty. After 16 idle cycles expect out_data=0x00005AA5, out_keep=4'b0011, out_last=1. With the macro off, out_valid stays 0 for 100 cycles.
- **Reset mid-word:** pop 3 bytes, assert rrst for 1 cycle in the same cycle as the capture of byte 3. Expect all outputs at reset values. The next 4 bytes 0x10..0x13 produce 0x13121110 with no residue from before reset.
- **Status:** with rempty_almost toggling in FILL, low_water follows it one cycle later. In HOLD, low_water = 0.
